// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped branch target buffer with saturating counters and statistics
module branch_predictor_btb #(
  parameter int PC_W   = 16,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [PC_W-1:0]   pc_if,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_next_pc,
  input  logic              upd_valid,
  input  logic              upd_is_branch,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_target,
  input  logic [PC_W-1:0]   upd_pred_target,
  input  logic              upd_pred_taken,
  output logic              mispredict,
  output logic [PC_W-1:0]   fix_pc,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_INIT = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [PC_W-1:0]  tgt_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q   [ENTRIES];

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit;
  logic             br_upd, do_train, do_alloc, do_inval;
  logic [CNT_W-1:0] cnt_d;

  assign l_idx = pc_if[IDX_W-1:0];
  assign l_tag = pc_if[PC_W-1:IDX_W];
  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[PC_W-1:IDX_W];

  // Fetch-side lookup reads only registered state, so a same-cycle update is not visible here
  always_comb begin
    pred_hit     = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken   = mode && pred_hit && cnt_q[l_idx][CNT_W-1];
    pred_next_pc = pred_taken ? tgt_q[l_idx] : pc_if + PC_W'(1);
  end

  // Classify the resolved instruction and compute the trained counter value
  always_comb begin
    u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    br_upd   = upd_valid && upd_is_branch;
    do_train = br_upd && u_hit;
    do_alloc = br_upd && upd_taken && !u_hit;
    do_inval = upd_valid && !upd_is_branch && u_hit;
    cnt_d    = cnt_q[u_idx];
    if (upd_taken) begin
      if (cnt_q[u_idx] != CNT_MAX) cnt_d = cnt_q[u_idx] + CNT_W'(1);
    end else begin
      if (cnt_q[u_idx] != '0) cnt_d = cnt_q[u_idx] - CNT_W'(1);
    end
  end

  // Flush request and the PC fetch should restart from
  always_comb begin
    mispredict = upd_valid &&
                 ((upd_is_branch && ((upd_pred_taken != upd_taken) ||
                                     (upd_taken && (upd_pred_target != upd_target)))) ||
                  (!upd_is_branch && upd_pred_taken));
    fix_pc = (upd_is_branch && upd_taken) ? upd_target : upd_pc + PC_W'(1);
  end

  // Valid bits and counters: cleared by reset, then allocate / train / invalidate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
    end else if (do_alloc) begin
      valid_q[u_idx] <= 1'b1;
      cnt_q[u_idx]   <= CNT_INIT;
    end else if (do_train) begin
      cnt_q[u_idx] <= cnt_d;
    end else if (do_inval) begin
      valid_q[u_idx] <= 1'b0;
    end
  end

  // Tags and targets carry no reset; a cleared valid bit makes them irrelevant
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end else if (do_train && upd_taken) begin
      tgt_q[u_idx] <= upd_target;
    end
  end

  // Saturating statistics next-state; clear beats increment
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (stat_clr) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      if (br_upd && (branch_cnt_q != STAT_MAX)) branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mispredict && (mispred_cnt_q != STAT_MAX)) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  // Statistics registers; reset beats stat_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
